and_reg_pattern_checker: RTL and testbench
==========================================

Name: and_reg_pattern_checker

Overview:
- Self-checking stimulus/response block for the registered-AND test target (inputs a, b; registered output y = a AND b).
- Drives every a/b combination into the target and compares the returned y against the expected value after a fixed latency.
- Counts mismatches and reports pass/fail.
- Sits beside the target in netlist regression tops and shares its clock and reset.

Parameters:
- NUM_PASSES, 4, number of full sweeps through the 4 input vectors; N = 4*NUM_PASSES total vectors; legal range 1..64.
- LATENCY, 1, cycles from a vector appearing on a_out/b_out to the matching y_in being compared; legal range 1..4.
- ERR_W, 8, width of the mismatch counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to begin a run
- a_out  out  1  stimulus to target input a, registered
- b_out  out  1  stimulus to target input b, registered
- y_in  in  1  response from target output y
- busy  out  1  high in DRIVE and DRAIN
- done  out  1  high in DONE (level)
- pass  out  1  high in DONE when err_count == 0
- err_count  out  ERR_W  number of mismatches, saturating

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - a_out = b_out = busy = done = pass = 0, err_count = 0.
  - Vector index, sweep counter, drain counter and the expected pipeline are all cleared.
- States: IDLE, DRIVE, DRAIN, DONE. All outputs are registered.
- IDLE:
  - a_out = b_out = 0.
  - start = 1 sampled at edge E0 -> DRIVE from E0+1; counters are cleared at that same edge.
- DRIVE:
  - 2-bit vector index v, with a_out = v[1], b_out = v[0].
  - v starts at 0, increments every cycle and wraps 3 -> 0; the sweep counter increments on each wrap.
  - Exactly N consecutive DRIVE cycles, then DRAIN.
- Expected pipeline:
  - A LATENCY-deep shift register of {valid, exp}, where exp = a_out AND b_out.
  - It is loaded with valid = 1 every DRIVE cycle and valid = 0 otherwise.
  - When the tail entry is valid, y_in is compared against tail exp at the clock edge ending that cycle.
  - A vector driven in cycle n is therefore checked against y_in during cycle n+LATENCY.
- Mismatch: err_count increments by 1. At all-ones it holds (saturates) and does not wrap.
- DRAIN:
  - a_out = b_out = 0.
  - Lasts exactly LATENCY cycles so that the final vector is compared.
  - Then DONE.
- DONE:
  - done = 1; pass = (err_count == 0); err_count is held.
  - start = 1 -> DRIVE next cycle, clearing err_count, pass and done.
  - Otherwise the block remains in DONE indefinitely.
- Timing: with start at E0, DRIVE occupies cycles 1..N, DRAIN occupies cycles N+1..N+LATENCY, and done first reads 1 in cycle N+LATENCY+1.
- start is ignored while busy = 1.
- Reset mid-run aborts immediately to the reset values; no partial result is retained.
- y_in is ignored whenever the pipeline tail is invalid, including in IDLE, in DONE, and during the first LATENCY cycles of DRIVE.

Test Plan:
1. Defaults, correct target model (registered AND, 1-cycle latency), start pulse -> a/b sequence 00,01,10,11 repeated 4 times; done in cycle 18; err_count = 0; pass = 1.
2. Defaults, y_in tied 0 -> err_count = 4 (one per "11" vector); pass = 0.
3. Defaults, y_in tied 1 -> err_count = 12; pass = 0. With ERR_W = 2 -> err_count saturates at 3.
4. rst pulsed low during the 7th DRIVE cycle -> all outputs 0 immediately and state IDLE. A subsequent start produces a clean run with err_count = 0.
5. start re-pulsed during DRIVE -> ignored, run length still 16. start in DONE after a failing run -> counters clear, rerun passes, pass = 1.
6. LATENCY = 3 with target delayed by 2 extra registers -> err_count = 0 and done in cycle 20. Same target with LATENCY = 1 -> err_count nonzero.

Source files
------------

// File: rtl/and_reg_pattern_checker_if.sv
// Stimulus/response link between the pattern checker and the
// registered-AND target it exercises.
interface and_reg_pattern_checker_if;
    logic a_out;
    logic b_out;
    logic y_in;

    modport master (
        output a_out,
        output b_out,
        input  y_in
    );

    modport slave (
        input  a_out,
        input  b_out,
        output y_in
    );
endinterface

// File: rtl/and_reg_pattern_checker.sv
// Sweeps all a/b combinations into a registered-AND target and
// counts mismatches on the delayed y response.
module and_reg_pattern_checker #(
    parameter int NUM_PASSES = 4,
    parameter int LATENCY    = 1,
    parameter int ERR_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    and_reg_pattern_checker_if.master  tgt,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [ERR_W-1:0]           err_count
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DRAIN,
        DONE
    } state_t;

    localparam int SW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [SW-1:0] LAST_SWEEP = SW'(NUM_PASSES - 1);
    localparam logic [1:0]    LAST_DRAIN = 2'(LATENCY - 1);

    state_t             state_q;
    state_t             state_d;
    logic [1:0]         v_q;
    logic [1:0]         v_d;
    logic [SW-1:0]      sweep_q;
    logic [SW-1:0]      sweep_d;
    logic [1:0]         drain_q;
    logic [1:0]         drain_d;
    logic               a_q;
    logic               b_q;
    logic               a_d;
    logic               b_d;
    logic               busy_d;
    logic               done_d;
    logic               pass_d;
    logic [ERR_W-1:0]   err_d;
    logic [LATENCY-1:0] pv_q;
    logic [LATENCY-1:0] pe_q;
    logic               mismatch;

    assign tgt.a_out = a_q;
    assign tgt.b_out = b_q;

    // Only the tail of the expected pipe is ever compared with y_in.
    assign mismatch = pv_q[LATENCY-1] && (tgt.y_in != pe_q[LATENCY-1]);

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        sweep_d = sweep_q;
        drain_d = drain_q;
        a_d     = 1'b0;
        b_d     = 1'b0;
        busy_d  = busy;
        done_d  = done;
        pass_d  = pass;
        err_d   = err_count;
        if (mismatch && !(&err_count)) begin
            err_d = err_count + 1'b1;
        end
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    v_d     = 2'd0;
                    sweep_d = '0;
                    drain_d = 2'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                end
            end
            DRIVE: begin
                if (v_q == 2'd3 && sweep_q == LAST_SWEEP) begin
                    state_d = DRAIN;
                    drain_d = 2'd0;
                end else begin
                    v_d = v_q + 2'd1;
                    if (v_q == 2'd3) begin
                        sweep_d = sweep_q + 1'b1;
                    end
                    a_d = v_d[1];
                    b_d = v_d[0];
                end
            end
            DRAIN: begin
                // The final vector is judged on the same edge that enters DONE.
                if (drain_q == LAST_DRAIN) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            v_q       <= 2'd0;
            sweep_q   <= '0;
            drain_q   <= 2'd0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            pv_q      <= '0;
            pe_q      <= '0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            sweep_q   <= sweep_d;
            drain_q   <= drain_d;
            a_q       <= a_d;
            b_q       <= b_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            err_count <= err_d;
            pv_q[0]   <= (state_q == DRIVE);
            pe_q[0]   <= a_q & b_q;
            for (int i = 1; i < LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pe_q[i] <= pe_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_and_reg_pattern_checker.sv
// Two checkers (latency 1 and 3) each beside a configurable target,
// compared against a vector-level model of the expected run.
module tb_and_reg_pattern_checker;

    localparam int NP   = 4;
    localparam int NV   = 4 * NP;
    localparam int EW1  = 8;
    localparam int EW3  = 2;
    localparam int MAXC = NV + 3 + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;

    logic           busy1, done1, pass1;
    logic [EW1-1:0] err1;
    logic           busy3, done3, pass3;
    logic [EW3-1:0] err3;

    int n_checks = 0;
    int n_errors = 0;

    // target behaviour: 0 correct, 1 tied 0, 2 tied 1, 3 random
    int mode1 = 0;
    int mode3 = 0;
    int depth1 = 1;
    int depth3 = 3;

    logic [3:0] sr1 = '0;
    logic [3:0] sr3 = '0;
    logic       rnd1 = 1'b0;
    logic       rnd3 = 1'b0;

    logic y1h [0:MAXC];
    logic y3h [0:MAXC];

    always #5 clk = ~clk;

    and_reg_pattern_checker_if if1 ();
    and_reg_pattern_checker_if if3 ();

    and_reg_pattern_checker #(
        .NUM_PASSES (NP),
        .LATENCY    (1),
        .ERR_W      (EW1)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tgt       (if1),
        .busy      (busy1),
        .done      (done1),
        .pass      (pass1),
        .err_count (err1)
    );

    and_reg_pattern_checker #(
        .NUM_PASSES (NP),
        .LATENCY    (3),
        .ERR_W      (EW3)
    ) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tgt       (if3),
        .busy      (busy3),
        .done      (done3),
        .pass      (pass3),
        .err_count (err3)
    );

    always @(posedge clk) begin
        sr1  <= {sr1[2:0], if1.a_out & if1.b_out};
        sr3  <= {sr3[2:0], if3.a_out & if3.b_out};
        rnd1 <= 1'($urandom);
        rnd3 <= 1'($urandom);
    end

    function automatic logic tgt_y(input int mode, input int depth,
                                   input logic [3:0] sr, input logic rnd);
        case (mode)
            0:       return sr[depth-1];
            1:       return 1'b0;
            2:       return 1'b1;
            default: return rnd;
        endcase
    endfunction

    assign if1.y_in = tgt_y(mode1, depth1, sr1, rnd1);
    assign if3.y_in = tgt_y(mode3, depth3, sr3, rnd3);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {busy, done, a, b} expected in cycle c after the start edge
    function automatic logic [3:0] exp_stat(input int c, input int lat);
        int v;
        if (c <= NV) begin
            v = (c - 1) % 4;
            return {1'b1, 1'b0, v[1], v[0]};
        end
        if (c <= NV + lat) return 4'b1000;
        return 4'b0100;
    endfunction

    // vector k (1-based) is judged against y seen in cycle k+lat
    function automatic int exp_err(input int lat, input int ew, input bit is3);
        int n;
        int lim;
        logic e;
        logic y;
        n = 0;
        for (int k = 1; k <= NV; k++) begin
            e = ((k - 1) % 4 == 3);
            y = is3 ? y3h[k+lat] : y1h[k+lat];
            if (y !== e) n++;
        end
        lim = (1 << ew) - 1;
        return (n > lim) ? lim : n;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_1"}, {busy1, done1, pass1, if1.a_out, if1.b_out, 24'(err1)}, 0);
        chk({tag, "_3"}, {busy3, done3, pass3, if3.a_out, if3.b_out, 30'(err3)}, 0);
    endtask

    task automatic run(input int m1, input int m3, input int d1, input int d3,
                       input bit repulse, input int rst_at);
        int e1;
        int e3;
        mode1  = m1;
        mode3  = m3;
        depth1 = d1;
        depth3 = d3;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= MAXC; c++) begin
            @(negedge clk);
            start = repulse && (c == 5);
            if (c == rst_at) begin
                rst = 1'b0;
                #1;
                chk_idle($sformatf("abort_c%0d", c));
                @(negedge clk);
                rst = 1'b1;
                chk_idle("abort_hold");
                return;
            end
            y1h[c] = if1.y_in;
            y3h[c] = if3.y_in;
            chk($sformatf("stat1_c%0d", c),
                {busy1, done1, if1.a_out, if1.b_out}, exp_stat(c, 1));
            chk($sformatf("stat3_c%0d", c),
                {busy3, done3, if3.a_out, if3.b_out}, exp_stat(c, 3));
        end
        e1 = exp_err(1, EW1, 1'b0);
        e3 = exp_err(3, EW3, 1'b1);
        chk("err1", err1, e1);
        chk("pass1", pass1, (e1 == 0));
        chk("err3", err3, e3);
        chk("pass3", pass3, (e3 == 0));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b1;
        @(negedge clk);
        chk_idle("idle");

        run(0, 0, 1, 3, 1'b0, 0);
        chk("clean_err1", err1, 0);
        chk("clean_pass3", pass3, 1);

        run(1, 1, 1, 3, 1'b0, 0);
        chk("tied0_err1", err1, 4);
        chk("tied0_err3", err3, 3);

        run(2, 2, 1, 3, 1'b0, 0);
        chk("tied1_err1", err1, 12);
        chk("tied1_err3", err3, 3);

        run(0, 0, 1, 3, 1'b0, 7);
        run(0, 0, 1, 3, 1'b0, 0);
        chk("after_abort_pass1", pass1, 1);

        run(2, 2, 1, 3, 1'b0, 0);
        run(0, 0, 1, 3, 1'b1, 0);
        chk("rerun_pass1", pass1, 1);
        chk("rerun_pass3", pass3, 1);

        run(0, 0, 3, 1, 1'b0, 0);
        chk("skew_fail1", (err1 != 0), 1);
        chk("skew_fail3", (err3 != 0), 1);

        for (int i = 0; i < 8; i++) begin
            run($urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(1, 4), $urandom_range(1, 4),
                1'($urandom_range(0, 1)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
